// File: rtl/execute_hi_lo_unit.sv
// Execute-stage iterative multiply/divide unit owning the architectural HI/LO pair.
// One product/quotient bit per cycle; hazard stall is raised for HI/LO instructions while busy.
module execute_hi_lo_unit #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   DIV0_QUOT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             hi_lo_register_write_execute,
  input  logic [5:0]       ALU_function_execute,
  input  logic [WIDTH-1:0] src_a_execute,
  input  logic [WIDTH-1:0] src_b_execute,
  output logic [WIDTH-1:0] hi_lo_read_data_execute,
  output logic             hi_lo_stall_execute,
  output logic             busy,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam int         CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t                 state;
  logic [CW-1:0]          count;
  logic [2*WIDTH-1:0]     acc;
  logic [WIDTH-1:0]       op;
  logic [WIDTH-1:0]       a_raw;
  logic                   neg_q;
  logic                   neg_r;
  logic                   div0;
  logic [WIDTH-1:0]       hi_q;
  logic [WIDTH-1:0]       lo_q;

  // Magnitude of a two's-complement operand when the op is signed.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic is_signed);
    if (is_signed && v[WIDTH-1]) return -v;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  logic             wr;
  logic [5:0]       funct;
  logic             idle;
  logic             is_hilo_funct;
  logic             is_start_funct;
  logic             start;
  logic             mt_hi;
  logic             mt_lo;
  logic             op_signed;
  logic             op_is_mul;

  assign wr             = hi_lo_register_write_execute;
  assign funct          = ALU_function_execute;
  assign idle           = (state == S_IDLE);
  assign is_start_funct = (funct == F_MULT) || (funct == F_MULTU) ||
                          (funct == F_DIV)  || (funct == F_DIVU);
  assign is_hilo_funct  = is_start_funct || (funct == F_MFHI) || (funct == F_MTHI) ||
                          (funct == F_MFLO) || (funct == F_MTLO);
  assign start          = wr && idle && is_start_funct;
  assign mt_hi          = wr && idle && (funct == F_MTHI);
  assign mt_lo          = wr && idle && (funct == F_MTLO);
  assign op_signed      = (funct == F_MULT) || (funct == F_DIV);
  assign op_is_mul      = (funct == F_MULT) || (funct == F_MULTU);

  logic [WIDTH-1:0] sa_mag;
  logic [WIDTH-1:0] sb_mag;
  logic             sign_diff;

  assign sa_mag    = mag(src_a_execute, op_signed);
  assign sb_mag    = mag(src_b_execute, op_signed);
  assign sign_diff = op_signed && (src_a_execute[WIDTH-1] ^ src_b_execute[WIDTH-1]);

  // Shift-add step: acc = {partial product high, remaining multiplier bits}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_res;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign mul_res  = neg_2w(mul_next, neg_q);

  // Restoring step: acc = {partial remainder, dividend bits / quotient bits}.
  // For a nonzero divisor the remainder stays below it, so bit WIDTH of the trial is a clean borrow.
  logic [WIDTH:0]     div_trial;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   div_lo;
  logic [WIDTH-1:0]   div_hi;

  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, op};
  assign div_ok    = !div_trial[WIDTH];
  assign div_next  = div_ok ? {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                            : {acc[2*WIDTH-2:0], 1'b0};
  assign div_lo    = div0 ? DIV0_QUOT : neg_w(div_next[WIDTH-1:0], neg_q);
  assign div_hi    = div0 ? a_raw     : neg_w(div_next[2*WIDTH-1:WIDTH], neg_r);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= S_IDLE;
      count <= '0;
      acc   <= '0;
      op    <= '0;
      a_raw <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
      busy  <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            count <= CW'(WIDTH - 1);
            a_raw <= src_a_execute;
            neg_q <= sign_diff;
            if (op_is_mul) begin
              state <= S_MUL;
              op    <= sa_mag;
              acc   <= {{WIDTH{1'b0}}, sb_mag};
              neg_r <= 1'b0;
              div0  <= 1'b0;
            end else begin
              state <= S_DIV;
              op    <= sb_mag;
              acc   <= {{WIDTH{1'b0}}, sa_mag};
              neg_r <= op_signed && src_a_execute[WIDTH-1];
              div0  <= (src_b_execute == '0);
            end
          end else begin
            if (mt_hi) hi_q <= src_a_execute;
            if (mt_lo) lo_q <= src_a_execute;
          end
        end
        S_MUL: begin
          acc <= mul_next;
          if (count == '0) begin
            hi_q  <= mul_res[2*WIDTH-1:WIDTH];
            lo_q  <= mul_res[WIDTH-1:0];
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        S_DIV: begin
          acc <= div_next;
          if (count == '0) begin
            hi_q  <= div_hi;
            lo_q  <= div_lo;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign hi_out                  = hi_q;
  assign lo_out                  = lo_q;
  assign hi_lo_read_data_execute = (funct == F_MFHI) ? hi_q : lo_q;
  assign hi_lo_stall_execute     = busy && wr && is_hilo_funct;

endmodule
